// File: rtl/alu_seq_pkg.sv
// Shared opcode and FSM encodings for the sequential ALU.
package alu_seq_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_MUL  = 3'd2,
    OP_DIV  = 3'd3,
    OP_LAND = 3'd4,
    OP_AND  = 3'd5,
    OP_RAND = 3'd6,
    OP_CAT  = 3'd7
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_div_iter.sv
// Iterative restoring divider: one quotient bit per cycle, DATA_W cycles.
// done is asserted during the last iteration cycle and quotient/remainder
// then present that iteration's result, so the caller can register it on
// the same edge that retires the divide.
module alu_div_iter #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  localparam int CW = $clog2(DATA_W + 1);

  logic [CW-1:0]     cnt_q;
  logic [DATA_W-1:0] quo_q, rem_q, dsr_q;
  logic [DATA_W-1:0] quo_nxt, rem_nxt;
  logic [DATA_W:0]   rsh, diff;
  logic              ge;

  // One shift/subtract step: bring in the next dividend bit, subtract if it fits.
  always_comb begin
    rsh     = {rem_q, quo_q[DATA_W-1]};
    diff    = rsh - {1'b0, dsr_q};
    ge      = (rsh >= {1'b0, dsr_q});
    rem_nxt = ge ? diff[DATA_W-1:0] : rsh[DATA_W-1:0];
    quo_nxt = {quo_q[DATA_W-2:0], ge};
  end

  assign busy      = (cnt_q != '0);
  assign done      = (cnt_q == CW'(1));
  assign quotient  = quo_nxt;
  assign remainder = rem_nxt;

  // Load operands on start, then iterate until the counter drains.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dsr_q <= '0;
    end else if (start) begin
      cnt_q <= CW'(DATA_W);
      quo_q <= dividend;
      rem_q <= '0;
      dsr_q <= divisor;
    end else if (busy) begin
      cnt_q <= cnt_q - CW'(1);
      quo_q <= quo_nxt;
      rem_q <= rem_nxt;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential 8-opcode ALU with valid/ready handshakes, registered result,
// status flags and an iterative divider. One operation in flight at most.
import alu_seq_pkg::*;

module alu_seq #(
  parameter int DATA_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  input  logic [OP_W-1:0]     opcode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*DATA_W-1:0] y,
  output logic [DATA_W-1:0]   rem,
  output logic                carry,
  output logic                zero,
  output logic                div0
);

  localparam int YW = 2 * DATA_W;

  state_e            state_q, state_d;
  opcode_e           op;
  logic              accept, is_div, div_start;
  logic              div_busy, div_done;
  logic [DATA_W-1:0] div_q, div_r;
  logic [DATA_W:0]   sum, dif;
  logic [YW-1:0]     res_y;
  logic [DATA_W-1:0] res_rem;
  logic              res_carry, res_div0;

  assign op = opcode_e'(opcode);

  alu_div_iter #(.DATA_W(DATA_W)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .dividend  (a),
    .divisor   (b),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  // Handshake and next-state; in_ready is gated by rst_n so nothing is
  // accepted while reset is held.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      ST_IDLE: in_ready = 1'b1;
      ST_DONE: in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
    if (!rst_n) in_ready = 1'b0;

    accept    = in_valid && in_ready;
    // Divide by zero resolves in a single cycle, so only b!=0 goes iterative.
    is_div    = (op == OP_DIV) && (b != '0);
    div_start = accept && is_div;

    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = is_div ? ST_DIV : ST_DONE;
      end
      ST_DIV: begin
        if (div_done)      state_d = ST_DONE;
        else if (!div_busy) state_d = ST_IDLE; // divider lost its op: recover
      end
      ST_DONE: begin
        if (accept)         state_d = is_div ? ST_DIV : ST_DONE;
        else if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  assign out_valid = (state_q == ST_DONE);

  // Single-cycle datapath for every opcode except a real (b!=0) divide.
  always_comb begin
    sum       = {1'b0, a} + {1'b0, b};
    dif       = {1'b0, a} - {1'b0, b};
    res_y     = '0;
    res_rem   = '0;
    res_carry = 1'b0;
    res_div0  = 1'b0;
    case (op)
      OP_ADD: begin
        res_y     = YW'(sum);
        res_carry = sum[DATA_W];
      end
      OP_SUB: begin
        res_y     = {{DATA_W{dif[DATA_W]}}, dif[DATA_W-1:0]};
        res_carry = dif[DATA_W];
      end
      OP_MUL:  res_y = YW'(a) * YW'(b);
      OP_DIV: begin
        res_y    = '1;
        res_rem  = a;
        res_div0 = 1'b1;
      end
      OP_LAND: res_y = YW'((a != '0) && (b != '0));
      OP_AND:  res_y = YW'(a & b);
      OP_RAND: res_y = YW'(&a);
      OP_CAT:  res_y = {a, b};
      default: res_y = '0;
    endcase
  end

  // Result registers: loaded on a single-cycle accept or when the divide retires.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y     <= '0;
      rem   <= '0;
      carry <= 1'b0;
      zero  <= 1'b0;
      div0  <= 1'b0;
    end else if (accept && !is_div) begin
      y     <= res_y;
      rem   <= res_rem;
      carry <= res_carry;
      zero  <= (res_y == '0);
      div0  <= res_div0;
    end else if (state_q == ST_DIV && div_done) begin
      y     <= YW'(div_q);
      rem   <= div_r;
      carry <= 1'b0;
      zero  <= (div_q == '0);
      div0  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed test-plan sequences followed by
// randomized traffic, compared every cycle against a behavioural model.
module tb_alu_seq;

  localparam int DW = 4;
  localparam int YW = 2 * DW;

  typedef struct packed {
    logic [YW-1:0] y;
    logic [DW-1:0] rem;
    logic          carry;
    logic          zero;
    logic          div0;
  } res_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] a = '0;
  logic [DW-1:0] b = '0;
  logic [2:0]    opcode = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [YW-1:0] y;
  logic [DW-1:0] rem;
  logic          carry, zero, div0;

  int vectors = 0;
  int fails   = 0;

  alu_seq #(.DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .opcode    (opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .rem       (rem),
    .carry     (carry),
    .zero      (zero),
    .div0      (div0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the opcode definitions.
  function automatic res_t model(input logic [DW-1:0] ai, input logic [DW-1:0] bi, input logic [2:0] op);
    res_t r;
    int unsigned x, z, full;
    x = ai; z = bi; full = 1 << DW;
    r = '0;
    case (op)
      3'd0: begin r.y = YW'(x + z); r.carry = (x + z) >= full; end
      3'd1: begin
        r.carry = (x < z);
        r.y = YW'(((x + full - z) % full) + ((x < z) ? (full - 1) * full : 0));
      end
      3'd2: r.y = YW'(x * z);
      3'd3: begin
        if (z == 0) begin r.y = YW'(full * full - 1); r.rem = ai; r.div0 = 1'b1; end
        else begin r.y = YW'(x / z); r.rem = DW'(x % z); end
      end
      3'd4: r.y = YW'((x != 0 && z != 0) ? 1 : 0);
      3'd5: r.y = YW'(ai & bi);
      3'd6: r.y = YW'((x == full - 1) ? 1 : 0);
      default: r.y = YW'(x * full + z);
    endcase
    r.zero = (r.y == '0);
    return r;
  endfunction

  // ---------------- cycle model + compare process ----------------
  bit   started = 1'b0;
  bit   m_have  = 1'b0;  // a result is being offered
  bit   m_zero  = 1'b0;  // reset values still showing, no result since
  int   m_wait  = 0;     // cycles until a pending divide result appears
  res_t m_cur   = '0;
  res_t m_pend  = '0;

  // Inputs are stable at the falling edge: check outputs, then advance the
  // model across the coming rising edge.
  always @(negedge clk) begin
    logic e_rdy;
    logic acc;
    res_t r;
    e_rdy = rst_n && (m_wait == 0) && (!m_have || out_ready);
    if (started) begin
      chk("in_ready", 64'(in_ready), 64'(e_rdy));
      chk("out_valid", 64'(out_valid), 64'(m_have));
      if (m_have || m_zero)
        chk("result{y,rem,c,z,d0}", 64'({y, rem, carry, zero, div0}), 64'(m_cur));
    end
    if (!rst_n) begin
      m_have = 1'b0; m_wait = 0; m_cur = '0; m_zero = 1'b1;
    end else begin
      acc = in_valid && e_rdy;
      if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) begin m_have = 1'b1; m_cur = m_pend; m_zero = 1'b0; end
      end else if (m_have && out_ready) begin
        m_have = 1'b0;
      end
      if (acc) begin
        r = model(a, b, opcode);
        if (opcode == 3'd3 && b != '0) begin
          m_wait = DW; m_pend = r; m_have = 1'b0;
        end else begin
          m_have = 1'b1; m_cur = r; m_zero = 1'b0;
        end
      end
    end
    started = 1'b1;
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Present an op and hold it until the DUT takes it; in_valid stays high so
  // the caller may chain the next op into the drain cycle.
  task automatic issue(input logic [DW-1:0] ta, input logic [DW-1:0] tbv, input logic [2:0] top);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1; a = ta; b = tbv; opcode = top;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
    end
    if (!acc) chk("issue_timeout", 64'(0), 64'(1));
  endtask

  task automatic pin(input string name, input logic [DW-1:0] ta, input logic [DW-1:0] tbv,
                     input logic [2:0] top, input res_t exp);
    res_t r;
    r = model(ta, tbv, top);
    chk(name, 64'(r), 64'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit last_acc;
    // Hand-computed expectations that pin the model ({y, rem, carry, zero, div0}).
    pin("model_add",  4'd9,  4'd8,  3'd0, '{y:8'h11, rem:4'h0, carry:1'b1, zero:1'b0, div0:1'b0});
    pin("model_sub",  4'd3,  4'd5,  3'd1, '{y:8'hFE, rem:4'h0, carry:1'b1, zero:1'b0, div0:1'b0});
    pin("model_cat",  4'hA,  4'h5,  3'd7, '{y:8'hA5, rem:4'h0, carry:1'b0, zero:1'b0, div0:1'b0});
    pin("model_div",  4'd13, 4'd4,  3'd3, '{y:8'h03, rem:4'h1, carry:1'b0, zero:1'b0, div0:1'b0});
    pin("model_div1", 4'd15, 4'd15, 3'd3, '{y:8'h01, rem:4'h0, carry:1'b0, zero:1'b0, div0:1'b0});
    pin("model_div0", 4'd7,  4'd0,  3'd3, '{y:8'hFF, rem:4'h7, carry:1'b0, zero:1'b0, div0:1'b1});
    pin("model_rand", 4'hE,  4'h0,  3'd6, '{y:8'h00, rem:4'h0, carry:1'b0, zero:1'b1, div0:1'b0});
    pin("model_mul",  4'd15, 4'd15, 3'd2, '{y:8'hE1, rem:4'h0, carry:1'b0, zero:1'b0, div0:1'b0});
    pin("model_land", 4'd0,  4'd5,  3'd4, '{y:8'h00, rem:4'h0, carry:1'b0, zero:1'b1, div0:1'b0});

    // Reset
    rst_n = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    idle(1);

    // Directed test plan
    out_ready = 1'b1;
    issue(4'd9, 4'd8, 3'd0);  idle(2);
    issue(4'd3, 4'd5, 3'd1);  issue(4'hA, 4'h5, 3'd7);  idle(2);
    issue(4'd13, 4'd4, 3'd3); issue(4'd15, 4'd15, 3'd3); idle(DW + 3);
    issue(4'd7, 4'd0, 3'd3);  issue(4'hE, 4'h0, 3'd6);  idle(2);
    out_ready = 1'b0;
    issue(4'd15, 4'd15, 3'd2); idle(3);
    out_ready = 1'b1;
    idle(2);
    // Reset during the second divide cycle
    issue(4'd14, 4'd3, 3'd3); idle(1);
    rst_n = 1'b0; @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    issue(4'd0, 4'd5, 3'd4);  idle(3);

    // Randomized traffic
    last_acc = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      out_ready = ($urandom % 4) != 0;
      rst_n     = ($urandom % 200) != 0;
      if (!in_valid || last_acc) begin
        in_valid = ($urandom % 3) != 0;
        a        = ($urandom % 8 == 0) ? '0 : DW'($urandom);
        b        = ($urandom % 6 == 0) ? '0 : DW'($urandom);
        opcode   = ($urandom % 3 == 0) ? 3'd3 : 3'($urandom);
      end
      @(negedge clk); last_acc = in_valid && in_ready;
      @(posedge clk); #1;
    end
    rst_n = 1'b1; out_ready = 1'b1;
    idle(DW + 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Sequential, parametrised successor to the team's combinational 8-opcode ALU.
- Same opcode set, generalised to DATA_W-bit operands with a 2*DATA_W-bit result.
- Adds valid/ready handshakes, a registered result, status flags, a remainder output and a multi-cycle iterative divider.
- Sits between an operand producer and a result consumer; holds at most one operation in flight.

Parameters:
DATA_W, 4, operand width in bits (result is 2*DATA_W); legal range 2..32

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
in_valid  input  1  operand/opcode present
in_ready  output  1  block accepts operands this cycle
a  input  DATA_W  operand A (unsigned)
b  input  DATA_W  operand B (unsigned)
opcode  input  3  0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 LAND, 5 AND, 6 RAND, 7 CAT
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
y  output  2*DATA_W  result
rem  output  DATA_W  DIV remainder; 0 for other opcodes
carry  output  1  ADD carry-out / SUB borrow; 0 otherwise
zero  output  1  y == 0
div0  output  1  DIV with b == 0

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=IDLE; out_valid, y, rem, carry, zero, div0 all 0.
  - in_ready is forced 0 while rst_n is low.
  - Reset has priority over everything and aborts an in-progress divide with no output.
- Accept event = in_valid && in_ready. a, b and opcode are captured at that edge; input changes afterwards have no effect.
- FSM states:
  - IDLE: in_ready=1, out_valid=0.
  - DIV: in_ready=0, out_valid=0; iterative restoring divide, one quotient bit per cycle, DATA_W cycles.
  - DONE: out_valid=1; y, rem and flags held stable until out_ready.
- Transitions:
  - IDLE + accept, opcode!=DIV or (DIV with b==0) -> DONE; latency 1.
  - IDLE + accept, DIV with b!=0 -> DIV.
  - DIV, DATA_W cycles elapsed -> DONE. Total latency accept-to-out_valid = DATA_W+1.
  - DONE && out_ready && !in_valid -> IDLE.
  - DONE && out_ready && in_valid -> the new operation is accepted in the same cycle (in_ready = out_ready in DONE) and follows the IDLE+accept rules. A non-DIV result therefore gives back-to-back out_valid; a DIV drops out_valid for DATA_W cycles.
  - DONE && !out_ready: hold; in_ready=0.
- Arithmetic (unsigned; result zero-extended to 2*DATA_W unless stated):
  - ADD: y = a+b; carry = bit DATA_W of the sum.
  - SUB: y[DATA_W-1:0] = a-b mod 2^DATA_W, upper half = replicated borrow; carry = (a<b).
  - MUL: full 2*DATA_W product.
  - DIV: y = quotient, rem = remainder.
  - DIV b==0: y = all ones, rem = a, div0=1.
  - LAND: y = (a!=0 && b!=0).
  - AND: y = a&b.
  - RAND: y = &a.
  - CAT: y = {a,b}.
- zero is computed on the final y for every opcode, including div0.
- Flags and rem are 0 for opcodes that do not define them.

Decomposition:
- Package alu_seq_pkg: opcode constants (OP_ADD..OP_CAT), state encodings (ST_IDLE, ST_DIV, ST_DONE), opcode width constant 3.
- Sub-module alu_div_iter (DATA_W parameter):
  - inputs: start, dividend, divisor.
  - outputs: busy, done (one-cycle pulse), quotient, remainder.
  - Contains the shift/subtract datapath and iteration counter; must accept the same synchronous active-low reset.
- Top level holds the FSM, the single-cycle datapath and the output registers.

Test Plan:
- ADD a=9 b=8, out_ready=1 -> out_valid exactly 1 cycle after accept; y=0x11, carry=1, zero=0.
- SUB a=3 b=5 -> y=0xFE, carry=1. Then CAT a=0xA b=0x5 back-to-back in the drain cycle -> y=0xA5; out_valid stays high both cycles.
- DIV a=13 b=4 -> in_ready=0 for 4 cycles; out_valid 5 cycles after accept; y=0x03, rem=1, div0=0. A second DIV (a=15, b=15) issued in the drain cycle -> y=0x01, rem=0, out_valid low for 4 cycles between the two results.
- DIV a=7 b=0 -> latency 1; y=0xFF, rem=7, div0=1, zero=0. RAND a=0xE -> y=0, zero=1.
- MUL a=15 b=15 with out_ready=0 for 3 cycles -> y=0xE1 stable and in_ready=0 throughout; releasing out_ready returns the FSM to IDLE next cycle.
- Reset mid-divide: DIV a=14 b=3, rst_n low on 2nd DIV cycle for 1 cycle -> out_valid never asserts for that op; all outputs 0; in_ready=1 first cycle after rst_n rises. A following LAND a=0 b=5 -> y=0, zero=1.
